// File: rtl/display_scheduler.sv
// Display arbiter: owns the 8-digit bus and chooses between the base view,
// a timed message and a timed, blinking alert, handshaking via req/ack.
module display_scheduler #(
  parameter int          TICK_DIV   = 100000,
  parameter int          MSG_MS     = 2000,
  parameter int          ALERT_MS   = 3000,
  parameter int          BLINK_MS   = 250,
  parameter logic [4:0]  BLANK_CODE = 5'h1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] base_dig,
  input  logic        msg_req,
  input  logic [39:0] msg_dig,
  output logic        msg_ack,
  output logic        msg_done,
  input  logic        alert_req,
  input  logic [39:0] alert_dig,
  output logic        alert_ack,
  output logic [39:0] dig,
  output logic [1:0]  mode
);

  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_MAX = (MSG_MS > ALERT_MS) ? MSG_MS : ALERT_MS;
  localparam int CNT_W    = $clog2(HOLD_MAX + 1);
  localparam int BLK_W    = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_MSG   = 2'b01;
  localparam logic [1:0] S_ALERT = 2'b10;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] hold_lim;
  logic [BLK_W-1:0] blk_cnt;
  logic             blink_dark;
  logic [39:0]      msg_lat;
  logic [39:0]      alert_lat;
  logic             tick;
  logic             expire;
  logic             msg_take;
  logic             alert_take;
  logic             acc_msg;
  logic             acc_alert;
  logic             done_nxt;

  assign tick     = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign hold_lim = (state == S_ALERT) ? CNT_W'(ALERT_MS - 1) : CNT_W'(MSG_MS - 1);
  assign expire   = tick && (tick_cnt == hold_lim);
  // A request still high in the cycle its ack is visible is the old one.
  assign msg_take   = msg_req && !msg_ack;
  assign alert_take = alert_req && !alert_ack;
  assign mode       = state;

  always_comb begin
    state_nxt = state;
    acc_msg   = 1'b0;
    acc_alert = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (alert_take) begin
          acc_alert = 1'b1;
          state_nxt = S_ALERT;
        end else if (msg_take) begin
          acc_msg   = 1'b1;
          state_nxt = S_MSG;
        end
      end
      S_MSG: begin
        if (alert_take) begin
          acc_alert = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_ALERT;
        end else if (msg_take) begin
          acc_msg   = 1'b1;
        end else if (expire) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ALERT: begin
        if (alert_take) begin
          acc_alert = 1'b1;
        end else if (expire) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      msg_ack    <= 1'b0;
      alert_ack  <= 1'b0;
      msg_done   <= 1'b0;
      msg_lat    <= '0;
      alert_lat  <= '0;
      pre_cnt    <= '0;
      tick_cnt   <= '0;
      blk_cnt    <= '0;
      blink_dark <= 1'b0;
      dig        <= '0;
    end else begin
      state     <= state_nxt;
      msg_ack   <= acc_msg;
      alert_ack <= acc_alert;
      msg_done  <= done_nxt;
      if (acc_msg)   msg_lat   <= msg_dig;
      if (acc_alert) alert_lat <= alert_dig;

      // Every accept restarts the timebase so hold durations are exact.
      if (acc_msg || acc_alert) begin
        pre_cnt    <= '0;
        tick_cnt   <= '0;
        blk_cnt    <= '0;
        blink_dark <= 1'b0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (tick && (tick_cnt != CNT_W'(HOLD_MAX)))
          tick_cnt <= tick_cnt + 1'b1;
        if (state_nxt != S_ALERT) begin
          blk_cnt    <= '0;
          blink_dark <= 1'b0;
        end else if (tick) begin
          if (blk_cnt == BLK_W'(BLINK_MS - 1)) begin
            blk_cnt    <= '0;
            blink_dark <= ~blink_dark;
          end else begin
            blk_cnt <= blk_cnt + 1'b1;
          end
        end
      end

      // Output bus follows the registered state one cycle later.
      case (state)
        S_MSG:   dig <= msg_lat;
        S_ALERT: dig <= blink_dark ? {8{BLANK_CODE}} : alert_lat;
        default: dig <= base_dig;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with short timebase parameters.
module tb_display_scheduler;

  logic        clk;
  logic        rst;
  logic [39:0] base_dig;
  logic        msg_req;
  logic [39:0] msg_dig;
  logic        msg_ack;
  logic        msg_done;
  logic        alert_req;
  logic [39:0] alert_dig;
  logic        alert_ack;
  logic [39:0] dig;
  logic [1:0]  mode;

  int n_cmp;
  int n_err;

  localparam logic [39:0] BASE  = 40'h0123456789;
  localparam logic [39:0] ALRT  = 40'h0842108421;
  localparam logic [39:0] DARK  = 40'hFFFFFFFFFF;

  display_scheduler #(
    .TICK_DIV(4), .MSG_MS(5), .ALERT_MS(6), .BLINK_MS(2), .BLANK_CODE(5'h1F)
  ) dut (
    .clk(clk), .rst(rst), .base_dig(base_dig),
    .msg_req(msg_req), .msg_dig(msg_dig), .msg_ack(msg_ack), .msg_done(msg_done),
    .alert_req(alert_req), .alert_dig(alert_dig), .alert_ack(alert_ack),
    .dig(dig), .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic seen;

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; base_dig = BASE;
    msg_req = 1'b0; msg_dig = '0; alert_req = 1'b0; alert_dig = '0;

    // 1: reset and base view
    cyc(2);
    chk("rst_dig", dig, 40'h0);
    chk("rst_mode", 40'(mode), 40'h0);
    chk("rst_ack", 40'({msg_ack, alert_ack, msg_done}), 40'h0);
    rst = 1'b0;
    cyc(1);
    chk("idle_dig", dig, BASE);
    chk("idle_mode", 40'(mode), 40'h0);

    // 2: message accept and expiry
    msg_req = 1'b1; msg_dig = 40'hAAAAAAAAAA;
    cyc(1);
    chk("m_ack", 40'(msg_ack), 40'h1);
    chk("m_mode", 40'(mode), 40'h1);
    msg_req = 1'b0;
    cyc(1);
    chk("m_dig", dig, 40'hAAAAAAAAAA);
    chk("m_ack_pulse", 40'(msg_ack), 40'h0);
    cyc(18);
    chk("m_hold19", 40'(mode), 40'h1);
    chk("m_nodone19", 40'(msg_done), 40'h0);
    cyc(1);
    chk("m_exp_mode", 40'(mode), 40'h0);
    chk("m_exp_done", 40'(msg_done), 40'h1);
    cyc(1);
    chk("m_exp_dig", dig, BASE);
    chk("m_done_pulse", 40'(msg_done), 40'h0);

    // 3: alert preempts a message, blinking
    msg_req = 1'b1; msg_dig = 40'h1111111111;
    cyc(1);
    msg_req = 1'b0;
    cyc(7);
    alert_req = 1'b1; alert_dig = ALRT;
    cyc(1);
    chk("a_ack", 40'(alert_ack), 40'h1);
    chk("a_preempt_done", 40'(msg_done), 40'h1);
    chk("a_mode", 40'(mode), 40'h2);
    alert_req = 1'b0;
    cyc(1);
    chk("a_dig1", dig, ALRT);
    chk("a_done_pulse", 40'(msg_done), 40'h0);
    cyc(7);
    chk("a_dig8", dig, ALRT);
    cyc(1);
    chk("a_dark9", dig, DARK);
    cyc(7);
    chk("a_dark16", dig, DARK);
    cyc(1);
    chk("a_vis17", dig, ALRT);
    cyc(6);
    chk("a_hold23", 40'(mode), 40'h2);
    cyc(1);
    chk("a_exp_mode", 40'(mode), 40'h0);
    chk("a_exp_nodone", 40'(msg_done), 40'h0);
    cyc(1);
    chk("a_exp_dig", dig, BASE);

    // 4: simultaneous requests, message waits out the alert
    alert_req = 1'b1; alert_dig = 40'h3333333333;
    msg_req = 1'b1; msg_dig = 40'h2222222222;
    cyc(1);
    chk("p_alert_ack", 40'(alert_ack), 40'h1);
    chk("p_msg_ack", 40'(msg_ack), 40'h0);
    chk("p_mode", 40'(mode), 40'h2);
    alert_req = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      cyc(1);
      seen = seen | msg_ack;
    end
    chk("p_pending_noack", 40'(seen), 40'h0);
    chk("p_hold23", 40'(mode), 40'h2);
    cyc(1);
    chk("p_exp_mode", 40'(mode), 40'h0);
    chk("p_exp_noack", 40'(msg_ack), 40'h0);
    cyc(1);
    chk("p_late_ack", 40'(msg_ack), 40'h1);
    chk("p_late_mode", 40'(mode), 40'h1);
    msg_req = 1'b0;
    cyc(1);
    chk("p_late_dig", dig, 40'h2222222222);
    cyc(19);
    chk("p_msg_exp", 40'(mode), 40'h0);
    cyc(1);

    // 5: message replaced mid-hold
    msg_req = 1'b1; msg_dig = 40'h4444444444;
    cyc(1);
    msg_req = 1'b0;
    cyc(9);
    msg_req = 1'b1; msg_dig = 40'h5555555555;
    cyc(1);
    chk("r_ack", 40'(msg_ack), 40'h1);
    chk("r_nodone", 40'(msg_done), 40'h0);
    chk("r_mode", 40'(mode), 40'h1);
    cyc(1);
    chk("r_no_double_ack", 40'(msg_ack), 40'h0);
    chk("r_dig", dig, 40'h5555555555);
    msg_req = 1'b0;
    cyc(18);
    chk("r_hold19", 40'(mode), 40'h1);
    chk("r_nodone19", 40'(msg_done), 40'h0);
    cyc(1);
    chk("r_exp_mode", 40'(mode), 40'h0);
    chk("r_exp_done", 40'(msg_done), 40'h1);
    cyc(1);

    // 6: asynchronous reset during a dark phase
    alert_req = 1'b1; alert_dig = ALRT;
    cyc(1);
    alert_req = 1'b0;
    cyc(9);
    chk("x_dark", dig, DARK);
    chk("x_mode", 40'(mode), 40'h2);
    #2 rst = 1'b1;
    #1;
    chk("x_rst_dig", dig, 40'h0);
    chk("x_rst_mode", 40'(mode), 40'h0);
    chk("x_rst_done", 40'(msg_done), 40'h0);
    cyc(1);
    rst = 1'b0;
    base_dig = 40'hABCDE00000;
    cyc(1);
    chk("x_post_dig", dig, 40'hABCDE00000);
    chk("x_post_mode", 40'(mode), 40'h0);
    chk("x_post_done", 40'(msg_done), 40'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Owns the 40-bit digit bus (8 digits x 5-bit codes) that drives seven_seg_display.
- Arbitrates three sources: a persistent base view (balance or price), a timed message channel (prompts, change due), and a timed, blinking alert channel (fault, sold out).
- Handles priority, hold timing and blinking so that shop logic only issues req/ack transactions.

Parameters:
- TICK_DIV, 100000: clk cycles per 1 ms timebase tick (100 MHz clock).
- MSG_MS, 2000: message hold time, in ticks.
- ALERT_MS, 3000: alert hold time, in ticks.
- BLINK_MS, 250: alert blink half-period, in ticks.
- BLANK_CODE, 5'h1F: per-digit code rendered dark by seven_seg_dec.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- base_dig  in  40  default content; sampled continuously.
- msg_req  in  1  message request; level, held until acked.
- msg_dig  in  40  message content; valid while msg_req=1.
- msg_ack  out  1  1-cycle pulse; msg_dig latched.
- msg_done  out  1  1-cycle pulse; message expired or was preempted.
- alert_req  in  1  alert request; level, held until acked.
- alert_dig  in  40  alert content; valid while alert_req=1.
- alert_ack  out  1  1-cycle pulse; alert_dig latched.
- dig  out  40  registered digit bus to seven_seg_display.
- mode  out  2  00 IDLE, 01 MSG, 10 ALERT (registered).

Behaviour:
- Reset (async):
  - state=IDLE, mode=00, dig=0.
  - All acks and msg_done=0.
  - Latches, prescaler, tick counter and blink phase cleared.
- Clearing prescaler and timer on every accept gives deterministic durations.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick asserts on wrap.
  - Prescaler and tick counter clear on every accept (ack cycle).
- Acceptance: on ack edge, content is latched, the ack pulses, and state/mode update at the same edge.
- IDLE:
  - alert_req=1 -> accept alert, go ALERT.
  - Else msg_req=1 -> accept message, go MSG.
- MSG:
  - alert_req=1 -> accept alert, go ALERT; msg_done pulses on the same edge (preempted).
  - Else msg_req=1 -> relatch new message, ack, restart timer, stay MSG; no msg_done.
  - Else timer expiry -> IDLE, msg_done pulses.
- ALERT:
  - alert_req=1 -> relatch, ack, restart timer; blink phase resets to visible.
  - Expiry -> IDLE.
  - msg_req is never acked in ALERT; it stays pending.
- Priority: simultaneous alert_req and msg_req -> alert wins; msg_ack stays 0.
- Expiry: the state leaves exactly MSG_MS*TICK_DIV (or ALERT_MS*TICK_DIV) clk cycles after the accepting edge.
- A request pending at the expiry edge is evaluated from IDLE in the next cycle. There is no direct MSG->MSG on expiry.
- dig is registered, one cycle after state/latch:
  - IDLE: base_dig (tracks changes with 1-cycle latency).
  - MSG: latched msg.
  - ALERT, visible phase: latched alert.
  - ALERT, dark phase: {8{BLANK_CODE}}.
- Blink phase:
  - Visible on entry.
  - Toggles every BLINK_MS ticks while in ALERT.
  - Forced visible on leaving ALERT.
- Acks are never asserted for 2 consecutive cycles for the same request. The requester must drop req the cycle after seeing ack; a req still high 2 cycles later is treated as a new request.
- Reset mid-MSG/ALERT: immediate return to IDLE; no msg_done pulse.
- Widths:
  - Prescaler: ceil(log2(TICK_DIV)) bits.
  - Tick counter: wide enough for max(MSG_MS, ALERT_MS).
  - No overflow: the counter saturates and is never compared past the limit.

Test Plan:
All scenarios use TICK_DIV=4, MSG_MS=5, ALERT_MS=6, BLINK_MS=2, BLANK_CODE=5'h1F.
1. Reset, then base_dig=40'h01234_56789 -> dig=0 during reset; dig=base 1 cycle after the first post-reset edge; mode=00.
2. msg_req with msg_dig=40'hAAAAA_AAAAA -> msg_ack pulse, mode=01, dig=AAAAA_AAAAA next cycle. 20 cycles after ack: mode=00, msg_done pulse, dig=base one cycle later.
3. alert_req 8 cycles into a message, alert_dig=40'h0842108421 -> alert_ack and msg_done on the same edge, mode=10.
   - dig alternates alert / 40'hFFFFFFFFFF every 8 cycles.
   - Returns to IDLE 24 cycles after alert ack.
4. alert_req and msg_req asserted on the same edge -> only alert_ack.
   - msg_req held through ALERT: msg_ack stays 0.
   - msg_ack issued in the first IDLE cycle after alert expiry.
5. Second msg_req (new data) 10 cycles into a message -> ack, dig updates, no msg_done; expiry 20 cycles after the second ack.
6. rst asserted mid-ALERT on a dark phase, asynchronously -> dig=0, mode=00 immediately; no msg_done; after release, normal IDLE.
